// File: rtl/tone_pkg.sv
// Shared types for the tone sequencer: state encoding, note-word fields and the pitch table.
// Pure definitions; no timing or flow control of its own.
package tone_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_NEXT  = 3'd4
    } state_e;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int DUR_W   = 4;
    localparam int PITCH_W = 4;
    localparam int HP_W    = 17;
    localparam int CNT_W   = 32;

    // Half-period counts at 50 MHz, chromatic C4..D5; entry 0 is a rest and never used.
    localparam logic [HP_W-1:0] HALF_PERIOD [16] = '{
        17'd0,     17'd95420, 17'd90253, 17'd85034,
        17'd80386, 17'd75758, 17'd71633, 17'd67568,
        17'd63776, 17'd60241, 17'd56818, 17'd53648,
        17'd50607, 17'd47801, 17'd45126, 17'd42589
    };

    function automatic logic [HP_W-1:0] half_period(input logic [PITCH_W-1:0] pitch,
                                                    input int unsigned     shift);
        return HALF_PERIOD[pitch] >> shift;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave divider: output starts low when enabled and toggles every half period of the pitch.
// Output is registered toggle masked by enable, so it drops in the same cycle enable falls.
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned HP_SHIFT = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [PITCH_W-1:0] pitch_i,
    output logic               buzz_o
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic [HP_W-1:0] hp;
    logic            tog_q, tog_d;

    always_comb begin
        hp    = half_period(pitch_i, HP_SHIFT);
        cnt_d = cnt_q;
        tog_d = tog_q;
        // Disabled or rest: hold the divider cleared so every note restarts from phase zero.
        if (!enable_i || pitch_i == '0) begin
            cnt_d = '0;
            tog_d = 1'b0;
        end else if (cnt_q == hp - HP_W'(1)) begin
            cnt_d = '0;
            tog_d = ~tog_q;
        end else begin
            cnt_d = cnt_q + HP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end

    assign buzz_o = tog_q & enable_i;

endmodule

// File: rtl/tone_sequencer.sv
// Plays note words from an external ROM (1-cycle read latency) as a buzzer tone; no backpressure.
// Optional TONE_SEQ_LOOP_EN repeats the start..stop range until interrupt, start or reset.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned BEAT_TICKS = 6250000,
    parameter int unsigned HP_SHIFT   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] stop_addr_i,
    input  logic              interrupt_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              busy_o,
    output logic              buzz_o
);

    localparam logic [CNT_W-1:0] BEAT = CNT_W'(BEAT_TICKS);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  stop_q, stop_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic [CNT_W-1:0]   play_cnt_q, play_cnt_d;
    logic [DUR_W-1:0]   rom_dur;
`ifdef TONE_SEQ_LOOP_EN
    logic [ADDR_W-1:0]  start_q, start_d;
`endif

    assign rom_dur = rom_data_i[DATA_W-1 -: DUR_W];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stop_d     = stop_q;
        pitch_d    = pitch_q;
        play_cnt_d = play_cnt_q;
`ifdef TONE_SEQ_LOOP_EN
        start_d    = start_q;
`endif
        if (state_q != ST_IDLE && interrupt_i) begin
            state_d = ST_IDLE;
        end else if (start_i && !interrupt_i) begin
            // Also a retrigger when busy: the current note is simply abandoned.
            state_d = ST_FETCH;
            addr_d  = start_addr_i;
            stop_d  = stop_addr_i;
`ifdef TONE_SEQ_LOOP_EN
            start_d = start_addr_i;
`endif
        end else begin
            unique case (state_q)
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    pitch_d = rom_data_i[PITCH_W-1:0];
                    if (rom_dur == '0) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d    = ST_PLAY;
                        play_cnt_d = CNT_W'(rom_dur) * BEAT - CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (play_cnt_q == '0) begin
                        state_d = ST_NEXT;
                    end else begin
                        play_cnt_d = play_cnt_q - CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (addr_q == stop_q) begin
`ifdef TONE_SEQ_LOOP_EN
                        state_d = ST_FETCH;
                        addr_d  = start_q;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_FETCH;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            stop_q     <= '0;
            pitch_q    <= '0;
            play_cnt_q <= '0;
`ifdef TONE_SEQ_LOOP_EN
            start_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stop_q     <= stop_d;
            pitch_q    <= pitch_d;
            play_cnt_q <= play_cnt_d;
`ifdef TONE_SEQ_LOOP_EN
            start_q    <= start_d;
`endif
        end
    end

    tone_gen #(
        .HP_SHIFT (HP_SHIFT)
    ) u_tone_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .enable_i (state_q == ST_PLAY),
        .pitch_i  (pitch_q),
        .buzz_o   (buzz_o)
    );

    assign rom_addr_o = addr_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
